// File: rtl/me_pkg.sv
// Shared constants, state encoding and search-pattern offset tables for the
// hexagonal-search motion-estimation sequencer.
package me_pkg;

    localparam int NUM_MB       = 36;
    localparam int MB_W         = 6;
    localparam int COORD_W      = 7;
    localparam int SEARCH_RANGE = 8;
    localparam int SAD_W        = 16;
    localparam int MAX_ITER     = 8;
    localparam int ITER_W       = 3;
    localparam int MV_W         = 5;
    // Candidate arithmetic width: one bit for the sign, one for the carry past
    // the coordinate range, so edge-of-frame candidates can be detected.
    localparam int EXT_W        = COORD_W + 2;
    localparam int PAT_N        = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EVAL_C = 3'd2,
        ST_LHEX   = 3'd3,
        ST_SHEX   = 3'd4,
        ST_OUT    = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // Large hexagon, visited in this order around the pass centre.
    localparam logic signed [2:0] LHEX_DX [PAT_N] = '{3'sd2, 3'sd1, -3'sd1, -3'sd2, -3'sd1, 3'sd1};
    localparam logic signed [2:0] LHEX_DY [PAT_N] = '{3'sd0, 3'sd2, 3'sd2, 3'sd0, -3'sd2, -3'sd2};
    // Small diamond finish.
    localparam logic signed [2:0] SHEX_DX [4] = '{3'sd1, 3'sd0, -3'sd1, 3'sd0};
    localparam logic signed [2:0] SHEX_DY [4] = '{3'sd0, 3'sd1, 3'sd0, -3'sd1};

    localparam logic [2:0] LHEX_LAST = 3'd5;
    localparam logic [2:0] SHEX_LAST = 3'd3;

endpackage

// File: rtl/hex_pattern_rom.sv
// Combinational lookup of one search-pattern offset: pattern select and
// point index in, (dx,dy) and the pattern's last valid index out.
module hex_pattern_rom
    import me_pkg::*;
(
    input  logic              pattern_sel_i,  // 0: large hexagon, 1: small diamond
    input  logic [2:0]        idx_i,
    output logic signed [2:0] dx_o,
    output logic signed [2:0] dy_o,
    output logic [2:0]        last_idx_o
);

    // Table lookup; indices past the end of a pattern return a zero offset.
    always_comb begin
        dx_o       = '0;
        dy_o       = '0;
        last_idx_o = LHEX_LAST;
        if (pattern_sel_i) begin
            last_idx_o = SHEX_LAST;
            if (idx_i <= SHEX_LAST) begin
                dx_o = SHEX_DX[idx_i[1:0]];
                dy_o = SHEX_DY[idx_i[1:0]];
            end
        end else if (idx_i <= LHEX_LAST) begin
            dx_o = LHEX_DX[idx_i];
            dy_o = LHEX_DY[idx_i];
        end
    end

endmodule

// File: rtl/hex_search_controller.sv
// Per-frame hexagonal-search sequencer: walks the macroblocks of a frame,
// runs large-hexagon refinement then a small-diamond finish against an
// external SAD unit, and emits one motion vector per macroblock.
//
// Handshakes: sad_req/cand_x/cand_y are registered and held until a cycle
// with sad_req=1 and sad_valid=1 (the accept); the next candidate appears on
// the cycle after the accept. mv_valid/mv_*/best_sad are held until a cycle
// with mv_valid=1 and mv_ready=1. sad_valid is ignored while sad_req=0.
module hex_search_controller
    import me_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [MB_W-1:0]    mb_counter,
    input  logic [COORD_W-1:0] x_centre,
    input  logic [COORD_W-1:0] y_centre,
    output logic [COORD_W-1:0] cand_x,
    output logic [COORD_W-1:0] cand_y,
    output logic               sad_req,
    input  logic               sad_valid,
    input  logic [SAD_W-1:0]   sad_value,
    output logic [MV_W-1:0]    mv_x,
    output logic [MV_W-1:0]    mv_y,
    output logic [SAD_W-1:0]   best_sad,
    output logic               mv_valid,
    input  logic               mv_ready,
    output logic               busy,
    output logic               frame_done,
    output logic [2:0]         dbg_state
);

    localparam logic signed [EXT_W-1:0] RANGE_POS = EXT_W'(SEARCH_RANGE);
    localparam logic signed [EXT_W-1:0] RANGE_NEG = -RANGE_POS;
    localparam logic signed [EXT_W-1:0] COORD_MAX = EXT_W'((1 << COORD_W) - 1);
    localparam logic [ITER_W-1:0]       ITER_LAST = ITER_W'(MAX_ITER - 1);

    state_e               state_q;
    logic [MB_W-1:0]      mb_q;
    logic [COORD_W-1:0]   ref_x_q, ref_y_q;
    logic [COORD_W-1:0]   best_x_q, best_y_q;
    logic [COORD_W-1:0]   pat_x_q, pat_y_q;   // centre of the current pattern pass
    logic [COORD_W-1:0]   cand_x_q, cand_y_q;
    logic [SAD_W-1:0]     best_sad_q;
    logic [ITER_W-1:0]    iter_q;
    logic [2:0]           idx_q;              // first pattern index not yet issued
    logic                 sad_req_q;
    logic                 mv_valid_q;
    logic [MV_W-1:0]      mv_x_q, mv_y_q;
    logic                 busy_q;
    logic                 frame_done_q;

    logic                 pattern_sel;
    logic signed [2:0]    rom_dx   [PAT_N];
    logic signed [2:0]    rom_dy   [PAT_N];
    logic [2:0]           rom_last [PAT_N];

    assign pattern_sel = (state_q == ST_SHEX);

    // One ROM port per pattern point so every point can be range-checked in
    // the same cycle; out-of-range points are then skipped without a bubble.
    for (genvar k = 0; k < PAT_N; k++) begin : g_rom
        hex_pattern_rom u_rom (
            .pattern_sel_i (pattern_sel),
            .idx_i         (3'(k)),
            .dx_o          (rom_dx[k]),
            .dy_o          (rom_dy[k]),
            .last_idx_o    (rom_last[k])
        );
    end

    logic signed [EXT_W-1:0] pt_x [PAT_N];
    logic signed [EXT_W-1:0] pt_y [PAT_N];
    logic signed [EXT_W-1:0] off_x [PAT_N];
    logic signed [EXT_W-1:0] off_y [PAT_N];
    logic                    pt_ok [PAT_N];
    logic                    scan_found;
    logic [2:0]              scan_idx;
    logic [COORD_W-1:0]      scan_x, scan_y;

    // Find the lowest pending pattern point that lies inside the search window.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_x     = '0;
        scan_y     = '0;
        for (int k = 0; k < PAT_N; k++) begin
            pt_x[k]  = $signed({2'b00, pat_x_q}) + $signed({{(EXT_W-3){rom_dx[k][2]}}, rom_dx[k]});
            pt_y[k]  = $signed({2'b00, pat_y_q}) + $signed({{(EXT_W-3){rom_dy[k][2]}}, rom_dy[k]});
            off_x[k] = pt_x[k] - $signed({2'b00, ref_x_q});
            off_y[k] = pt_y[k] - $signed({2'b00, ref_y_q});
            pt_ok[k] = (3'(k) >= idx_q) && (3'(k) <= rom_last[k])
                    && (off_x[k] >= RANGE_NEG) && (off_x[k] <= RANGE_POS)
                    && (off_y[k] >= RANGE_NEG) && (off_y[k] <= RANGE_POS)
                    && (pt_x[k] >= '0) && (pt_x[k] <= COORD_MAX)
                    && (pt_y[k] >= '0) && (pt_y[k] <= COORD_MAX);
        end
        for (int k = PAT_N - 1; k >= 0; k--) begin
            if (pt_ok[k]) begin
                scan_found = 1'b1;
                scan_idx   = 3'(k);
                scan_x     = pt_x[k][COORD_W-1:0];
                scan_y     = pt_y[k][COORD_W-1:0];
            end
        end
    end

    logic               accept;
    logic               better;
    logic [COORD_W-1:0] best_nx_x, best_nx_y;
    logic [SAD_W-1:0]   best_nx_sad;
    logic               pass_moved;
    logic [MV_W-1:0]    mv_nx_x, mv_nx_y;

    // Best point including the result being accepted this cycle. The centre
    // result always replaces the all-ones seed; later points need strictly lower.
    always_comb begin
        accept      = sad_req_q & sad_valid;
        better      = accept & ((state_q == ST_EVAL_C) | (sad_value < best_sad_q));
        best_nx_x   = better ? cand_x_q  : best_x_q;
        best_nx_y   = better ? cand_y_q  : best_y_q;
        best_nx_sad = better ? sad_value : best_sad_q;
        pass_moved  = (best_nx_x != pat_x_q) | (best_nx_y != pat_y_q);
        // The window bound keeps the difference within 5-bit two's complement.
        mv_nx_x     = MV_W'(best_nx_x) - MV_W'(ref_x_q);
        mv_nx_y     = MV_W'(best_nx_y) - MV_W'(ref_y_q);
    end

    // Search sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mb_q         <= '0;
            ref_x_q      <= '0;
            ref_y_q      <= '0;
            best_x_q     <= '0;
            best_y_q     <= '0;
            pat_x_q      <= '0;
            pat_y_q      <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            best_sad_q   <= '0;
            iter_q       <= '0;
            idx_q        <= '0;
            sad_req_q    <= 1'b0;
            mv_valid_q   <= 1'b0;
            mv_x_q       <= '0;
            mv_y_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        mb_q    <= '0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ref_x_q    <= x_centre;
                    ref_y_q    <= y_centre;
                    best_x_q   <= x_centre;
                    best_y_q   <= y_centre;
                    pat_x_q    <= x_centre;
                    pat_y_q    <= y_centre;
                    cand_x_q   <= x_centre;
                    cand_y_q   <= y_centre;
                    best_sad_q <= '1;
                    iter_q     <= '0;
                    idx_q      <= '0;
                    sad_req_q  <= 1'b1;
                    state_q    <= ST_EVAL_C;
                end
                ST_EVAL_C, ST_LHEX, ST_SHEX: begin
                    if (!sad_req_q || sad_valid) begin
                        best_x_q   <= best_nx_x;
                        best_y_q   <= best_nx_y;
                        best_sad_q <= best_nx_sad;
                        if (scan_found) begin
                            cand_x_q  <= scan_x;
                            cand_y_q  <= scan_y;
                            sad_req_q <= 1'b1;
                            idx_q     <= scan_idx + 3'd1;
                            if (state_q == ST_EVAL_C) begin
                                state_q <= ST_LHEX;
                            end
                        end else begin
                            // Pass finished: recentre on the best point found so far.
                            sad_req_q <= 1'b0;
                            idx_q     <= '0;
                            pat_x_q   <= best_nx_x;
                            pat_y_q   <= best_nx_y;
                            if (state_q == ST_SHEX) begin
                                mv_x_q     <= mv_nx_x;
                                mv_y_q     <= mv_nx_y;
                                mv_valid_q <= 1'b1;
                                state_q    <= ST_OUT;
                            end else if (pass_moved && (iter_q < ITER_LAST)) begin
                                iter_q  <= iter_q + ITER_W'(1);
                                state_q <= ST_LHEX;
                            end else begin
                                state_q <= ST_SHEX;
                            end
                        end
                    end
                end
                ST_OUT: begin
                    if (mv_ready) begin
                        mv_valid_q <= 1'b0;
                        if (mb_q == MB_W'(NUM_MB - 1)) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            mb_q    <= mb_q + MB_W'(1);
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    mb_q         <= '0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mb_counter = mb_q;
    assign cand_x     = cand_x_q;
    assign cand_y     = cand_y_q;
    assign sad_req    = sad_req_q;
    assign mv_x       = mv_x_q;
    assign mv_y       = mv_y_q;
    assign best_sad   = best_sad_q;
    assign mv_valid   = mv_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_hex_search_controller.sv
// Bench for hex_search_controller: a SAD unit model and an MV consumer run
// alongside one directed sequence of frames; expected motion vectors come
// from a loop-based model of the hexagonal search.
module tb_hex_search_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] mb_counter;
  logic [6:0] x_centre, y_centre;
  logic [6:0] cand_x, cand_y;
  logic       sad_req;
  logic       sad_valid;
  logic [15:0] sad_value;
  logic [4:0] mv_x, mv_y;
  logic [15:0] best_sad;
  logic       mv_valid;
  logic       mv_ready;
  logic       busy;
  logic       frame_done;
  logic [2:0] dbg_state;

  hex_search_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mb_counter(mb_counter),
    .x_centre(x_centre), .y_centre(y_centre), .cand_x(cand_x), .cand_y(cand_y),
    .sad_req(sad_req), .sad_valid(sad_valid), .sad_value(sad_value),
    .mv_x(mv_x), .mv_y(mv_y), .best_sad(best_sad), .mv_valid(mv_valid),
    .mv_ready(mv_ready), .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int mode, lat_max, stall_max, noise_en, seed, tgt_x, tgt_y;
  int exp_mb, n_mv, n_done, lat_left, stall_left;
  bit first_req_pending, have_prev, prev_acc, mv_prev_valid;
  logic [6:0] prev_x, prev_y;
  logic [25:0] prev_mv;
  logic [25:0] exp_q[$];

  int lhex_dx[6] = '{2, 1, -1, -2, -1, 1};
  int lhex_dy[6] = '{0, 2, 2, 0, -2, -2};
  int shex_dx[4] = '{1, 0, -1, 0};
  int shex_dy[4] = '{0, 1, 0, -1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Centre LUT: a diagonal from (16,16) at mb 0 to (80,80) at mb 35.
  function automatic int lut_c(input int mb);
    return 16 + (mb * 64) / 35;
  endfunction

  always_comb begin
    x_centre = 7'(lut_c(int'(mb_counter)));
    y_centre = 7'(lut_c(int'(mb_counter)));
  end

  function automatic int sad_fn(input int x, input int y, input int rx, input int ry);
    int dx, dy;
    dx = x - rx;
    dy = y - ry;
    case (mode)
      0: return 100;
      1: return iabs(dx - 3) + iabs(dy + 2);
      2: return iabs(dx - 12) + iabs(dy);
      3: return ((dx == 0 && dy == 0) || (dx == 2 && dy == 0)) ? 50 : 100;
      4: begin
        if (dx == 1 && dy == 2) return 40;
        return ((dx == 0 && dy == 0) || (dx == 2 && dy == 0)) ? 50 : 100;
      end
      default: return 4 * (iabs(dx - tgt_x) + iabs(dy - tgt_y)) + ((x * 7 + y * 13 + seed) % 5);
    endcase
  endfunction

  function automatic bit cand_ok(input int x, input int y, input int rx, input int ry);
    return iabs(x - rx) <= 8 && iabs(y - ry) <= 8 && x >= 0 && x <= 127 && y >= 0 && y <= 127;
  endfunction

  // Reference search: up to 8 hexagon passes recentring on the best point,
  // then one diamond pass; strictly lower SAD wins, earlier point wins ties.
  function automatic logic [25:0] model_mb(input int rx, input int ry);
    int bx, by, bs, cx, cy, x, y, s;
    bx = rx; by = ry;
    bs = sad_fn(rx, ry, rx, ry);
    for (int p = 0; p < 8; p++) begin
      cx = bx; cy = by;
      for (int k = 0; k < 6; k++) begin
        x = cx + lhex_dx[k]; y = cy + lhex_dy[k];
        if (cand_ok(x, y, rx, ry)) begin
          s = sad_fn(x, y, rx, ry);
          if (s < bs) begin bs = s; bx = x; by = y; end
        end
      end
      if (bx == cx && by == cy) break;
    end
    cx = bx; cy = by;
    for (int k = 0; k < 4; k++) begin
      x = cx + shex_dx[k]; y = cy + shex_dy[k];
      if (cand_ok(x, y, rx, ry)) begin
        s = sad_fn(x, y, rx, ry);
        if (s < bs) begin bs = s; bx = x; by = y; end
      end
    end
    return {5'(bx - rx), 5'(by - ry), 16'(bs)};
  endfunction

  // ---------------- SAD unit driver / request monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      sad_valid = 1'b0;
      sad_value = '0;
      lat_left = -1;
      have_prev = 0;
    end else if (sad_req) begin
      if (have_prev && !prev_acc) begin
        chk("cand_x_hold", cand_x, prev_x);
        chk("cand_y_hold", cand_y, prev_y);
      end else begin
        chk("req_in_window", cand_ok(int'(cand_x), int'(cand_y), lut_c(exp_mb), lut_c(exp_mb)), 1);
        if (first_req_pending) begin
          chk("mb_counter", mb_counter, exp_mb);
          chk("centre_x", cand_x, lut_c(exp_mb));
          chk("centre_y", cand_y, lut_c(exp_mb));
          first_req_pending = 0;
        end
      end
      if (lat_left < 0) lat_left = int'($urandom_range(0, lat_max));
      if (lat_left == 0) begin
        sad_valid = 1'b1;
        sad_value = 16'(sad_fn(int'(cand_x), int'(cand_y), lut_c(exp_mb), lut_c(exp_mb)));
        lat_left = -1;
      end else begin
        sad_valid = 1'b0;
        lat_left--;
      end
      have_prev = 1;
      prev_acc = sad_valid;
      prev_x = cand_x;
      prev_y = cand_y;
    end else begin
      have_prev = 0;
      lat_left = -1;
      sad_valid = (noise_en != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      sad_value = 16'($urandom);
    end
  end

  // ---------------- MV consumer / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      mv_ready = 1'b0;
      stall_left = -1;
      mv_prev_valid = 0;
    end else if (mv_valid) begin
      if (mv_prev_valid) chk("mv_hold", {mv_x, mv_y, best_sad}, prev_mv);
      if (stall_left < 0) stall_left = int'($urandom_range(0, stall_max));
      if (stall_left == 0) begin
        mv_ready = 1'b1;
        chk("mv_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("mv_vs_model", {mv_x, mv_y, best_sad}, exp_q.pop_front());
        n_mv++;
        exp_mb++;
        first_req_pending = 1;
        stall_left = -1;
        mv_prev_valid = 0;
      end else begin
        mv_ready = 1'b0;
        stall_left--;
        mv_prev_valid = 1;
        prev_mv = {mv_x, mv_y, best_sad};
      end
    end else begin
      mv_ready = 1'b0;
      mv_prev_valid = 0;
    end
  end

  always @(negedge clk) if (rst_n && frame_done) n_done++;

  // ---------------- driver tasks ----------------
  task automatic setup_frame(input int m, input int lat, input int stall, input int noise);
    mode = m; lat_max = lat; stall_max = stall; noise_en = noise;
    seed = int'($urandom_range(0, 999));
    tgt_x = int'($urandom_range(0, 20)) - 10;
    tgt_y = int'($urandom_range(0, 20)) - 10;
    exp_q.delete();
    for (int mb = 0; mb < 36; mb++) exp_q.push_back(model_mb(lut_c(mb), lut_c(mb)));
    exp_mb = 0; n_mv = 0; n_done = 0; first_req_pending = 1;
  endtask

  task automatic run_frame(input string tag, input int m, input int lat, input int stall,
                           input int noise, input bit poke);
    int cyc;
    setup_frame(m, lat, stall, noise);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    cyc = 0;
    while (n_done == 0 && cyc < 30000) begin
      @(negedge clk);
      start = (poke && cyc == 100) ? 1'b1 : 1'b0;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_frame_done_seen"}, n_done != 0, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_frame_done_count"}, n_done, 1);
    chk({tag, "_mv_count"}, n_mv, 36);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_mb_end"}, mb_counter, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mb_counter"}, mb_counter, 0);
    chk({tag, "_cand_x"}, cand_x, 0);
    chk({tag, "_cand_y"}, cand_y, 0);
    chk({tag, "_sad_req"}, sad_req, 0);
    chk({tag, "_mv_x"}, mv_x, 0);
    chk({tag, "_mv_y"}, mv_y, 0);
    chk({tag, "_best_sad"}, best_sad, 0);
    chk({tag, "_mv_valid"}, mv_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; mode = 0; lat_max = 0; stall_max = 0; noise_en = 0;
    exp_mb = 0; first_req_pending = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Flat SAD: every MV (0,0) with best_sad 100.
    run_frame("flat", 0, 0, 0, 0, 0);
    // Bowl at (+3,-2): walks there with zero SAD.
    run_frame("bowl", 1, 0, 0, 1, 0);
    // Minimum at (+12,0): clamped to (+8,0) by the window.
    run_frame("clamp", 2, 0, 0, 0, 0);
    // Same bowl with slow SAD unit, consumer stalls and a start pulse mid-frame.
    run_frame("stall", 1, 5, 3, 1, 1);
    // Tie between centre and (+2,0) keeps the centre.
    run_frame("tie", 3, 1, 1, 0, 0);
    // Strictly lower at (+1,+2) takes the first step there.
    run_frame("step", 4, 0, 0, 0, 0);
    // Random landscapes with random handshake timing.
    run_frame("rand_a", 5, 2, 2, 1, 0);
    run_frame("rand_b", 5, 3, 1, 1, 0);

    // Asynchronous reset mid-search in macroblock 10.
    setup_frame(1, 1, 0, 0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (mb_counter != 6'd10 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach_mb10", mb_counter, 10);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_mv", n_mv, 10);
    chk("abort_idle_mv_valid", mv_valid, 0);
    run_frame("restart", 1, 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
